// File: rtl/clock_gate_ctrl.sv
// rtl/clock_gate_ctrl.sv - idle-timeout clock-gate enable FSM (optional CLOCK_GATE_STATS_EN wake counter)
module clock_gate_ctrl #(
    parameter int IDLE_TIMEOUT = 16,
    parameter int WAKE_DELAY   = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_force_on,
    output logic        o_clock_en,
    output logic        o_ready,
`ifdef CLOCK_GATE_STATS_EN
    output logic [15:0] o_wake_count,
`endif
    output logic [1:0]  o_state
);

    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
    localparam logic [IW-1:0] IDLE_TERM = IW'(IDLE_TIMEOUT);
    localparam logic [3:0]    WAKE_LAST = 4'(WAKE_DELAY - 1);

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        WAKE  = 2'b01,
        ON    = 2'b10,
        DRAIN = 2'b11
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   idle_q;
    logic [3:0]      wake_q;
    logic            active;

    assign active = i_req | i_force_on;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= OFF;
            idle_q  <= '0;
            wake_q  <= '0;
        end else begin
            case (state_q)
                OFF: begin
                    if (active) begin
                        state_q <= WAKE;
                        wake_q  <= '0;
                    end
                end
                WAKE: begin
                    // Requests are ignored here: the wake delay is fixed.
                    if (wake_q == WAKE_LAST) begin
                        state_q <= ON;
                        idle_q  <= '0;
                        wake_q  <= '0;
                    end else begin
                        wake_q <= wake_q + 4'd1;
                    end
                end
                ON: begin
                    if (active) begin
                        idle_q <= '0;
                    end else if (idle_q == IDLE_LAST) begin
                        idle_q  <= IDLE_TERM;
                        state_q <= DRAIN;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
                end
                DRAIN: begin
                    idle_q  <= '0;
                    state_q <= active ? ON : OFF;
                end
                default: state_q <= OFF;
            endcase
        end
    end

    // Outputs decode the state register only, so WAKE->ON->DRAIN->ON keeps enable high.
    assign o_state    = state_q;
    assign o_clock_en = (state_q != OFF);
    assign o_ready    = (state_q == ON);

`ifdef CLOCK_GATE_STATS_EN
    logic [15:0] wake_cnt_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wake_cnt_q <= '0;
        end else if (state_q == OFF && active && wake_cnt_q != 16'hFFFF) begin
            wake_cnt_q <= wake_cnt_q + 16'd1;
        end
    end

    assign o_wake_count = wake_cnt_q;
`endif

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// tb/tb_clock_gate_ctrl.sv - randomized self-checking bench for clock_gate_ctrl
module tb_clock_gate_ctrl;

    localparam int IDLE_TIMEOUT = 16;
    localparam int WAKE_DELAY   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        force_on;
    logic        clock_en;
    logic        ready;
    logic [1:0]  state;
`ifdef CLOCK_GATE_STATS_EN
    logic [15:0] wake_count;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: phase plus plain cycle tallies.
    int m_st;
    int m_wk;
    int m_idle;
    int m_wakes;

    clock_gate_ctrl #(.IDLE_TIMEOUT(IDLE_TIMEOUT), .WAKE_DELAY(WAKE_DELAY)) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_req        (req),
        .i_force_on   (force_on),
        .o_clock_en   (clock_en),
        .o_ready      (ready),
`ifdef CLOCK_GATE_STATS_EN
        .o_wake_count (wake_count),
`endif
        .o_state      (state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_st = 0; m_wk = 0; m_idle = 0; m_wakes = 0;
    endtask

    task automatic step();
        bit a;
        a = req | force_on;
        @(posedge clk);
        case (m_st)
            0: if (a) begin m_st = 1; m_wk = 0; if (m_wakes < 65535) m_wakes++; end
            1: begin m_wk++; if (m_wk == WAKE_DELAY) begin m_st = 2; m_idle = 0; end end
            2: if (a) m_idle = 0;
               else begin m_idle++; if (m_idle == IDLE_TIMEOUT) m_st = 3; end
            default: begin m_st = a ? 2 : 0; m_idle = 0; end
        endcase
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; force_on = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (clock_en !== 1'b0) $display("FAIL reset_en got %b want 0", clock_en); else n_pass++;
        n_total++;
        if (ready !== 1'b0) $display("FAIL reset_ready got %b want 0", ready); else n_pass++;
        n_total++;
        if (state !== 2'b00) $display("FAIL reset_state got %b want 00", state); else n_pass++;
`ifdef CLOCK_GATE_STATS_EN
        n_total++;
        if (wake_count !== 16'd0) $display("FAIL reset_wake_count got %0d want 0", wake_count); else n_pass++;
`endif
        rst = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_pulse();
        logic [1:0] want;
        req = 1'b1;
        step();
        req = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            want = 2'(m_st);
            n_total++;
            if (state !== want || clock_en !== (m_st != 0) || ready !== (m_st == 2))
                $display("FAIL pulse_cycle%0d got st=%b en=%b rdy=%b want st=%b", c, state, clock_en, ready, want);
            else n_pass++;
            if (c == 1 || c == 2 || c == 3 || c == 18 || c == 19 || c == 20) begin
                want = (c <= 2) ? 2'b01 : (c <= 18) ? 2'b10 : (c == 19) ? 2'b11 : 2'b00;
                n_total++;
                if (state !== want) $display("FAIL pulse_timeline t0+%0d got %b want %b", c, state, want);
                else n_pass++;
            end
            step();
        end
    endtask

    task automatic test_held();
        bit ok;
        req = 1'b1;
        for (int i = 0; i < 4; i++) step();
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (clock_en !== 1'b1 || ready !== 1'b1 || state !== 2'b10) ok = 1'b0;
            step();
        end
        n_total++;
        if (!ok || m_st != 2) $display("FAIL held_on got st=%b want 10 throughout", state); else n_pass++;
        req = 1'b0;
    endtask

    task automatic test_drain_rescue();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (m_st == 3) seen = 1'b1; else step();
        end
        n_total++;
        if (!seen || state !== 2'b11) $display("FAIL rescue_reach_drain got %b want 11", state); else n_pass++;
        req = 1'b1;
        step();
        req = 1'b0;
        n_total++;
        if (state !== 2'b10 || clock_en !== 1'b1 || ready !== 1'b1)
            $display("FAIL rescue_back_on got st=%b en=%b rdy=%b want 10/1/1", state, clock_en, ready);
        else n_pass++;
        for (int i = 0; i < 25; i++) step();
        n_total++;
        if (state !== 2'b00 || m_st != 0) $display("FAIL rescue_then_off got %b want 00", state); else n_pass++;
    endtask

    task automatic test_force();
        bit ok;
        force_on = 1'b1;
        for (int i = 0; i < 4; i++) step();
        ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (state !== 2'b10 || clock_en !== 1'b1) ok = 1'b0;
            step();
        end
        n_total++;
        if (!ok) $display("FAIL force_on_hold got st=%b want 10 throughout", state); else n_pass++;
        force_on = 1'b0;
        for (int i = 0; i < 20; i++) step();
        n_total++;
        if (state !== 2'(m_st)) $display("FAIL force_release got %b want %0d", state, m_st); else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 < 250) begin
                req      = ($urandom_range(0, 19) == 0);
                force_on = ($urandom_range(0, 59) == 0);
            end else begin
                req      = ($urandom_range(0, 2) == 0);
                force_on = 1'b0;
            end
            step();
            if (state !== 2'(m_st) || clock_en !== (m_st != 0) || ready !== (m_st == 2)) begin
                if (errs < 5)
                    $display("FAIL random_cycle%0d got st=%b en=%b rdy=%b want st=%0d", i, state, clock_en, ready, m_st);
                errs++;
            end
`ifdef CLOCK_GATE_STATS_EN
            if (wake_count !== 16'(m_wakes)) begin
                if (errs < 5) $display("FAIL random_wake_count got %0d want %0d", wake_count, m_wakes);
                errs++;
            end
`endif
        end
        n_total++;
        if (errs != 0) $display("FAIL random_total got %0d errors want 0", errs); else n_pass++;
        req = 1'b0; force_on = 1'b0;
        for (int i = 0; i < 25; i++) step();
    endtask

    task automatic test_async_reset();
        bit reached;
        reached = 1'b0;
        req = 1'b1;
        for (int i = 0; i < 10 && !reached; i++) begin
            step();
            if (m_st == 2) reached = 1'b1;
        end
        req = 1'b0;
        n_total++;
        if (!reached || state !== 2'b10) $display("FAIL areset_reach_on got %b want 10", state); else n_pass++;
        #3 rst = 1'b1;
        #1;
        n_total++;
        if (clock_en !== 1'b0 || state !== 2'b00 || ready !== 1'b0)
            $display("FAIL areset_immediate got en=%b st=%b rdy=%b want 0/00/0", clock_en, state, ready);
        else n_pass++;
        model_reset();
        req = 1'b1;
        #2 rst = 1'b0;
        step();
        n_total++;
        if (state !== 2'b01 || clock_en !== 1'b1) $display("FAIL areset_first_edge got st=%b en=%b want 01/1", state, clock_en);
        else n_pass++;
        req = 1'b0;
        for (int i = 0; i < 25; i++) step();
        n_total++;
        if (state !== 2'(m_st)) $display("FAIL areset_recover got %b want %0d", state, m_st); else n_pass++;
    endtask

`ifdef CLOCK_GATE_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        #3 rst = 1'b0;
        model_reset();
        for (int w = 0; w < 3; w++) begin
            req = 1'b1;
            step();
            req = 1'b0;
            for (int i = 0; i < 25; i++) step();
        end
        n_total++;
        if (wake_count !== 16'd3) $display("FAIL stats_three_wakes got %0d want 3", wake_count); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_pulse();
        test_held();
        test_drain_rescue();
        test_force();
        test_random();
        test_async_reset();
`ifdef CLOCK_GATE_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
